// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode instruction queue with flush
module fetch_queue #(
  parameter int             DEPTH     = 4,
  parameter int             NB_WORD   = 32,
  parameter int             NB_ADDR   = 32,
  parameter logic [31:0]    NOP_INSTR = 32'h00000013
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_push_valid,
  input  logic [NB_ADDR-1:0]         i_push_pc,
  input  logic [NB_WORD-1:0]         i_push_instr,
  output logic                       o_push_ready,
  output logic                       o_pop_valid,
  output logic [NB_ADDR-1:0]         o_pop_pc,
  output logic [NB_WORD-1:0]         o_pop_instr,
  input  logic                       i_pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int NB_PTR = $clog2(DEPTH);
  localparam int NB_CNT = $clog2(DEPTH + 1);
  localparam logic [NB_CNT-1:0] FULL_COUNT = NB_CNT'(DEPTH);

  logic [NB_ADDR-1:0] pc_mem    [DEPTH];
  logic [NB_WORD-1:0] instr_mem [DEPTH];

  logic [NB_PTR-1:0] wr_ptr;
  logic [NB_PTR-1:0] rd_ptr;
  logic [NB_CNT-1:0] count;

  logic push_fire;
  logic pop_fire;

  // Handshake qualifiers; full/empty come from the counter alone, and a flush
  // blocks both sides so fetch and decode see the redirect cycle as dead.
  always_comb begin
    o_push_ready = i_reset_n && !i_flush && (count < FULL_COUNT);
    o_pop_valid  = (count != '0) && !i_flush;
    push_fire    = i_push_valid && o_push_ready;
    pop_fire     = o_pop_valid && i_pop_ready;
  end

  // First-word fall-through head; an empty queue shows decode a NOP bubble.
  always_comb begin
    o_pop_pc    = '0;
    o_pop_instr = NB_WORD'(NOP_INSTR);
    if (o_pop_valid) begin
      o_pop_pc    = pc_mem[rd_ptr];
      o_pop_instr = instr_mem[rd_ptr];
    end
  end

  // Entry storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge i_clock) begin
    if (push_fire) begin
      pc_mem[wr_ptr]    <= i_push_pc;
      instr_mem[wr_ptr] <= i_push_instr;
    end
  end

  // Pointer and occupancy bookkeeping; flush drops every wrong-path entry.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_push_valid;
  logic [31:0] i_push_pc;
  logic [31:0] i_push_instr;
  logic        o_push_ready;
  logic        o_pop_valid;
  logic [31:0] o_pop_pc;
  logic [31:0] o_pop_instr;
  logic        i_pop_ready;
  logic [2:0]  o_count;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .NB_WORD(32), .NB_ADDR(32), .NOP_INSTR(NOP)) dut (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_flush      (i_flush),
    .i_push_valid (i_push_valid),
    .i_push_pc    (i_push_pc),
    .i_push_instr (i_push_instr),
    .o_push_ready (o_push_ready),
    .o_pop_valid  (o_pop_valid),
    .o_pop_pc     (o_pop_pc),
    .o_pop_instr  (o_pop_instr),
    .i_pop_ready  (i_pop_ready),
    .o_count      (o_count)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc << 8) ^ 32'h1A2B0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic pr,
                       input logic fl, output logic acc);
    logic        exp_ready;
    logic        exp_valid;
    logic [63:0] head;
    i_push_valid = pv;
    i_push_pc    = pc;
    i_push_instr = instr_of(pc);
    i_pop_ready  = pr;
    i_flush      = fl;
    @(negedge i_clock);
    exp_ready = !fl && (sb.size() < DEPTH);
    exp_valid = !fl && (sb.size() != 0);
    head = exp_valid ? sb[0] : {32'h0, NOP};
    chk("push_ready", {31'b0, o_push_ready}, {31'b0, exp_ready});
    chk("pop_valid",  {31'b0, o_pop_valid},  {31'b0, exp_valid});
    chk("pop_pc",     o_pop_pc,    head[63:32]);
    chk("pop_instr",  o_pop_instr, head[31:0]);
    chk("count",      {29'b0, o_count}, 32'(sb.size()));
    acc = pv && exp_ready;
    @(posedge i_clock);
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_valid && pr) void'(sb.pop_front());
      if (acc) sb.push_back({pc, instr_of(pc)});
    end
    #1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] pc;
    logic [15:0] pr_pat;

    i_reset_n    = 1'b0;
    i_flush      = 1'b0;
    i_push_valid = 1'b0;
    i_push_pc    = '0;
    i_push_instr = '0;
    i_pop_ready  = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", {31'b0, o_pop_valid},  32'd0);
    chk("rst_ready", {31'b0, o_push_ready}, 32'd0);
    chk("rst_count", {29'b0, o_count},      32'd0);
    chk("rst_instr", o_pop_instr,           NOP);
    chk("rst_pc",    o_pop_pc,              32'd0);
    @(posedge i_clock);
    @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;

    // Fill to full, dropped fifth push, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, acc);
    chk("fifth_dropped", {31'b0, acc}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Streaming: one-cycle latency, count stays 1 under push+pop
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Wrap-around with irregular decode stalls; fetch holds PC when refused
    pc     = 32'h200;
    pr_pat = 16'b0110_1001_1100_0101;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, pc, pr_pat[i], 1'b0, acc);
      if (acc) pc = pc + 32'd4;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Flush drops wrong-path entries and the concurrent push
    cycle(1'b1, 32'h20, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h28, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h2C, 1'b1, 1'b1, acc);
    chk("flush_push_dropped", {31'b0, acc}, 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h400, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-operation
    cycle(1'b1, 32'h40, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h44, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h48, 1'b0, 1'b0, acc);
    #2;
    i_push_valid = 1'b0;
    i_reset_n    = 1'b0;
    #1;
    chk("mid_rst_count", {29'b0, o_count},      32'd0);
    chk("mid_rst_valid", {31'b0, o_pop_valid},  32'd0);
    chk("mid_rst_ready", {31'b0, o_push_ready}, 32'd0);
    chk("mid_rst_instr", o_pop_instr,           NOP);
    sb.delete();
    @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;
    cycle(1'b1, 32'h80, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
